// File: rtl/fifo_arbiter.sv
// Round-robin arbiter feeding one shared FIFO, with per-requester locked bursts.
// Optional stall statistics counter is built only when FIFO_ARB_STATS_EN is defined.
module fifo_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int DEPTH_P2  = 5,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic                   full_bar,
    input  logic [DEPTH_P2:0]      fillcount,
    output logic [NREQ-1:0]        gnt,
    output logic                   put,
    output logic [WIDTH-1:0]       data_out,
    output logic                   locked,
    output logic [15:0]            stall_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = DEPTH_P2 + 2;

    typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              put_q, put_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              locked_q, locked_d;

    logic [NREQ-1:0]   gnt_s;
    logic              found_s;
    logic [PW-1:0]     arb_idx_s;
    logic              grant_s;
    logic [PW-1:0]     gidx_s;
    logic [HW-1:0]     fill_sum_s;
    logic              headroom_s;
    int                idx_s;

    // The in-flight write is counted so a registered put cannot overfill the FIFO.
    assign fill_sum_s = {1'b0, fillcount} + {{(HW-1){1'b0}}, put_q};
    assign headroom_s = full_bar && (fill_sum_s < (HW'(1) << DEPTH_P2));

    // Cyclic search for the first request at or after rr_ptr.
    always_comb begin
        found_s   = 1'b0;
        arb_idx_s = '0;
        idx_s     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(rr_ptr_q) + k) % NREQ;
            if (!found_s && req[idx_s]) begin
                found_s   = 1'b1;
                arb_idx_s = PW'(idx_s);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next-state, grant and write-port computation.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        put_d    = 1'b0;
        data_d   = data_q;
        grant_s  = 1'b0;
        gidx_s   = '0;
        gnt_s    = '0;
        case (state_q)
            ARB: begin
                if (headroom_s && found_s) begin
                    grant_s = 1'b1;
                    gidx_s  = arb_idx_s;
                    if (lock[arb_idx_s] && (MAX_BURST > 1)) begin
                        state_d = LOCKED;
                        owner_d = arb_idx_s;
                        beat_d  = BW'(1);
                    end else begin
                        state_d = ARB;
                    end
                end else begin
                    state_d = ARB;
                end
            end
            LOCKED: begin
                if (!lock[owner_q]) begin
                    state_d = ARB;
                    beat_d  = '0;
                end else if (headroom_s && req[owner_q]) begin
                    grant_s = 1'b1;
                    gidx_s  = owner_q;
                    if ((beat_q + BW'(1)) == BW'(MAX_BURST)) begin
                        state_d = ARB;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = ARB;
                beat_d  = '0;
            end
        endcase
        if (grant_s) begin
            gnt_s[gidx_s] = 1'b1;
            put_d         = 1'b1;
            data_d        = req_data[gidx_s*WIDTH +: WIDTH];
            rr_ptr_d      = (gidx_s == PW'(NREQ-1)) ? '0 : gidx_s + PW'(1);
        end else begin
            gnt_s         = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    // All arbiter state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            beat_q   <= '0;
            put_q    <= 1'b0;
            data_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            put_q    <= put_d;
            data_q   <= data_d;
            locked_q <= locked_d;
        end
    end

    assign gnt      = reset_n ? gnt_s : '0;
    assign put      = put_q;
    assign data_out = data_q;
    assign locked   = locked_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where someone waits only for lack of headroom.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req) && !headroom_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed self-checking bench for fifo_arbiter (NREQ=4, DEPTH_P2=5, MAX_BURST=8).
module tb_fifo_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_data;
    logic        full_bar;
    logic [5:0]  fillcount;
    logic [3:0]  gnt;
    logic        put;
    logic [7:0]  data_out;
    logic        locked;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_errors;
    int exp_stall;

`ifdef FIFO_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    fifo_arbiter #(
        .WIDTH(8), .NREQ(4), .DEPTH_P2(5), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
        .req_data(req_data), .full_bar(full_bar), .fillcount(fillcount),
        .gnt(gnt), .put(put), .data_out(data_out), .locked(locked),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag);
        check(tag, 32'(stall_cnt), STATS ? 32'(exp_stall) : 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;
        reset_n   = 1'b0;
        req       = 4'b1111;
        lock      = 4'b0000;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        full_bar  = 1'b1;
        fillcount = 6'd0;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_put", 32'(put), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check_stall("rst_stall");
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // Round robin with all four requesting.
        check("rr_put0", 32'(put), 32'h0);
        check("rr_g0", 32'(gnt), 32'h1);
        tick();
        check("rr_put1", 32'(put), 32'h1);
        check("rr_d1", 32'(data_out), 32'hA0);
        check("rr_g1", 32'(gnt), 32'h2);
        tick();
        check("rr_d2", 32'(data_out), 32'hA1);
        check("rr_g2", 32'(gnt), 32'h4);
        tick();
        check("rr_d3", 32'(data_out), 32'hA2);
        check("rr_g3", 32'(gnt), 32'h8);
        tick();
        check("rr_d4", 32'(data_out), 32'hA3);
        check("rr_g4", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        #1;
        check("idle_gnt", 32'(gnt), 32'h0);
        tick();
        check("idle_put", 32'(put), 32'h0);
        check("idle_hold", 32'(data_out), 32'hA0);
        check("idle_locked", 32'(locked), 32'h0);

        // Headroom boundary and full stall with a write in flight.
        req = 4'b0001;
        fillcount = 6'd30;
        #1;
        check("hr30_gnt", 32'(gnt), 32'h1);
        tick();
        fillcount = 6'd31;
        #1;
        check("full_put", 32'(put), 32'h1);
        check("full_gnt", 32'(gnt), 32'h0);
        tick();
        exp_stall++;
        check_stall("full_stall");
        check("full_noput", 32'(put), 32'h0);
        check("hr31_gnt", 32'(gnt), 32'h1);
        full_bar = 1'b0;
        #1;
        check("fb0_gnt", 32'(gnt), 32'h0);
        tick();
        exp_stall++;
        check_stall("fb0_stall");
        full_bar = 1'b1;
        fillcount = 6'd0;
        req = 4'b1000;
        #1;
        check("r3_gnt", 32'(gnt), 32'h8);
        tick();

        // Burst capped at MAX_BURST beats; rr_ptr is now 0.
        req = 4'b0011;
        lock = 4'b0001;
        for (int b = 1; b <= 8; b++) begin
            #1;
            check($sformatf("burst_g%0d", b), 32'(gnt), 32'h1);
            tick();
            check($sformatf("burst_lk%0d", b), 32'(locked), (b < 8) ? 32'h1 : 32'h0);
        end
        check("burst_d", 32'(data_out), 32'hA0);
        check("burst_next", 32'(gnt), 32'h2);
        tick();
        check("burst_d1", 32'(data_out), 32'hA1);
        check("burst_unlk", 32'(locked), 32'h0);

        // Early unlock after three beats, with one headroom stall inside the burst.
        req = 4'b1000;
        lock = 4'b0000;
        tick();
        req = 4'b0011;
        lock = 4'b0001;
        #1;
        check("eu_g1", 32'(gnt), 32'h1);
        tick();
        check("eu_lk1", 32'(locked), 32'h1);
        check("eu_g2", 32'(gnt), 32'h1);
        tick();
        full_bar = 1'b0;
        #1;
        check("eu_stall_g", 32'(gnt), 32'h0);
        tick();
        exp_stall++;
        check("eu_stall_lk", 32'(locked), 32'h1);
        check("eu_stall_put", 32'(put), 32'h0);
        check_stall("eu_stall_cnt");
        full_bar = 1'b1;
        #1;
        check("eu_g3", 32'(gnt), 32'h1);
        tick();
        lock = 4'b0000;
        #1;
        check("eu_exit_g", 32'(gnt), 32'h0);
        tick();
        check("eu_exit_lk", 32'(locked), 32'h0);
        check("eu_exit_put", 32'(put), 32'h0);
        check("eu_next", 32'(gnt), 32'h2);
        tick();

        // Reset in the middle of a burst; rr_ptr is 2 so the search wraps to 0.
        lock = 4'b0001;
        for (int b = 1; b <= 3; b++) begin
            #1;
            check($sformatf("rb_g%0d", b), 32'(gnt), 32'h1);
            tick();
        end
        check("rb_lk", 32'(locked), 32'h1);
        reset_n = 1'b0;
        exp_stall = 0;
        #1;
        check("rb_put", 32'(put), 32'h0);
        check("rb_locked", 32'(locked), 32'h0);
        check("rb_data", 32'(data_out), 32'h0);
        check("rb_gnt", 32'(gnt), 32'h0);
        check_stall("rb_stall");
        tick();
        reset_n = 1'b1;
        req = 4'b0110;
        lock = 4'b0000;
        #1;
        check("rb_rel_put", 32'(put), 32'h0);
        check("rb_rel_gnt", 32'(gnt), 32'h2);
        tick();
        check("rb_rel_d", 32'(data_out), 32'hA1);

        // Wrap from requester 3 back to requester 0.
        req = 4'b0100;
        tick();
        req = 4'b1001;
        #1;
        check("wrap_g3", 32'(gnt), 32'h8);
        tick();
        check("wrap_g0", 32'(gnt), 32'h1);
        tick();
        check("wrap_d", 32'(data_out), 32'hA0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
